fifo_param: RTL and testbench

Parametrised successor to the team's fixed 6-bit FIFO. Single-clock synchronous FIFO with generic data width and power-of-two depth.
- Adds runtime-programmable almost-empty/almost-full thresholds.
- Adds a hysteretic flow-control output (Pausa) and a read-data valid strobe.
- Separates overflow and underflow rejection cleanly.
- Sits between a producer and consumer in the datapath; Pausa drives back-pressure upstream.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ram_2p.sv | 48 ++++
 rtl/fifo_param.sv | 117 +++++++++++
 tb/tb_fifo_param.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and derived constants for fifo_param
package fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 6;
    localparam int ADDR_WIDTH_DEF  = 3;
    localparam int DEPTH_DEF       = 1 << ADDR_WIDTH_DEF;
    localparam int UMBRAL_BAJO_DEF = 2;
    localparam int UMBRAL_ALTO_DEF = 6;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// rtl/fifo_ram_2p.sv - simple dual-port RAM, one write port, one registered read port
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Read sees the pre-write contents when both ports hit the same entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds and hysteretic Pausa
// Optional build macro: FIFO_STICKY_ERROR_EN (Error_Fifo held until reset).
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   num_mem,
    output logic                  Fifo_Empty,
    output logic                  Fifo_Full,
    output logic                  Almost_Empty,
    output logic                  Almost_Full,
    output logic                  Pausa,
    output logic                  Error_Fifo
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   num_mem_q, num_mem_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  pausa_q, pausa_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;
    logic                  push_ok, pop_ok, rejected;

    assign pop_ok   = pop & ~empty_q;
    assign push_ok  = push & (~full_q | pop_ok);
    assign rejected = (push & ~push_ok) | (pop & ~pop_ok);

    always_comb begin
        wr_ptr_d       = push_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d       = pop_ok  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        num_mem_d      = num_mem_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
        empty_d        = (num_mem_d == '0);
        full_d         = (num_mem_d == DEPTH_CNT);
        almost_empty_d = (num_mem_d != '0) && (num_mem_d <= umbral_bajo);
        almost_full_d  = (num_mem_d >= umbral_alto) && (num_mem_d < DEPTH_CNT);
        valid_d        = pop_ok;
        // Hysteresis: between the two thresholds Pausa keeps its previous state.
        pausa_d = pausa_q;
        if (num_mem_d >= umbral_alto) begin
            pausa_d = 1'b1;
        end else if (num_mem_d <= umbral_bajo) begin
            pausa_d = 1'b0;
        end
`ifdef FIFO_STICKY_ERROR_EN
        error_d = error_q | rejected;
`else
        error_d = rejected;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            num_mem_q      <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b0;
            almost_full_q  <= 1'b0;
            pausa_q        <= 1'b0;
            error_q        <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            num_mem_q      <= num_mem_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            pausa_q        <= pausa_d;
            error_q        <= error_d;
            valid_q        <= valid_d;
        end
    end

    fifo_ram_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (Fifo_Data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (Fifo_Data_out)
    );

    assign data_valid   = valid_q;
    assign num_mem      = num_mem_q;
    assign Fifo_Empty   = empty_q;
    assign Fifo_Full    = full_q;
    assign Almost_Empty = almost_empty_q;
    assign Almost_Full  = almost_full_q;
    assign Pausa        = pausa_q;
    assign Error_Fifo   = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed plus randomized check of fifo_param against a queue model
module tb_fifo_param;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW:0]   lo = 4'd2;
    logic [AW:0]   hi = 4'd6;
    logic [DW-1:0] dout;
    logic          data_valid;
    logic [AW:0]   num_mem;
    logic          f_empty, f_full, a_empty, a_full, pausa, err;

    int vec_cnt = 0;
    int err_cnt = 0;

    int            q[$];
    logic [DW-1:0] m_data;
    logic          m_valid, m_err, m_pausa;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pop           (pop),
        .Fifo_Data_in  (din),
        .umbral_bajo   (lo),
        .umbral_alto   (hi),
        .Fifo_Data_out (dout),
        .data_valid    (data_valid),
        .num_mem       (num_mem),
        .Fifo_Empty    (f_empty),
        .Fifo_Full     (f_full),
        .Almost_Empty  (a_empty),
        .Almost_Full   (a_full),
        .Pausa         (pausa),
        .Error_Fifo    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the queue model, compare every output.
    task automatic step(input logic r, input logic p, input logic o, input logic [DW-1:0] d);
        int  n;
        bit  pop_ok, push_ok, rej;
        @(negedge clk);
        reset = r; push = p; pop = o; din = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_pausa = 1'b0;
        end else begin
            n       = q.size();
            pop_ok  = o && (n > 0);
            push_ok = p && ((n < DEPTH) || pop_ok);
            rej     = (p && !push_ok) || (o && !pop_ok);
            m_valid = pop_ok;
            if (pop_ok) m_data = DW'(q.pop_front());
            if (push_ok) q.push_back(int'(d));
            n = q.size();
            if (n >= int'(hi)) m_pausa = 1'b1;
            else if (n <= int'(lo)) m_pausa = 1'b0;
`ifdef FIFO_STICKY_ERROR_EN
            m_err = m_err || rej;
`else
            m_err = rej;
`endif
        end
        #1;
        n = q.size();
        check("data_out", 32'(dout), 32'(m_data));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("num_mem", 32'(num_mem), 32'(n));
        check("empty", 32'(f_empty), 32'(n == 0));
        check("full", 32'(f_full), 32'(n == DEPTH));
        check("almost_empty", 32'(a_empty), 32'((n > 0) && (n <= int'(lo))));
        check("almost_full", 32'(a_full), 32'((n >= int'(hi)) && (n < DEPTH)));
        check("pausa", 32'(pausa), 32'(m_pausa));
        check("error", 32'(err), 32'(m_err));
    endtask

    initial begin
        int k;
        m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_pausa = 1'b0;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, DW'(i));
        step(0, 1, 0, 6'h3F);
        for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
        // Empty push+pop, then fill and full push+pop with wrap.
        step(0, 1, 1, 6'h15);
        for (int i = 2; i <= 8; i++) step(0, 1, 0, DW'(i + 8));
        step(0, 1, 1, 6'h2A);
        for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
        // Reset mid-stream, then pop on empty.
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(i + 32));
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        // Error (sticky or not) across legal traffic.
        for (int i = 0; i < 20; i++) step(0, i[0] == 1'b0, i[0] == 1'b1, DW'(i));
        step(1, 0, 0, '0);
        // Randomized phases with varying bias and legal thresholds.
        for (int ph = 0; ph < 12; ph++) begin
            lo = 4'($urandom_range(0, 7));
            hi = 4'($urandom_range(int'(lo) + 1, 8));
            k  = $urandom_range(10, 90);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < k),
                     ($urandom_range(0, 99) < (100 - k)),
                     DW'($urandom));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
